// File: rtl/mips_prog_loader_if.sv
// Signal bundle between the MIPS program loader and its environment:
// host program stream, instruction memory, core control, register file, dump stream, status.
interface mips_prog_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RIDX_W = 5,
  parameter int CYC_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] prog_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_run;
  logic              core_halted;
  logic [RIDX_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RIDX_W-1:0] out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CYC_W-1:0]  cycles;

  // master: the loader itself; slave: host, memory, core and register file around it
  modport master (
    input  start, prog_len, in_valid, in_data, core_halted, rf_rdata, out_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, core_run, rf_raddr,
           out_valid, out_data, out_idx, out_last, busy, done, timeout, cycles
  );

  modport slave (
    output start, prog_len, in_valid, in_data, core_halted, rf_rdata, out_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_run, rf_raddr,
           out_valid, out_data, out_idx, out_last, busy, done, timeout, cycles
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Program loader / result harvester for the MIPS32 core: load imem, run to HALT, dump registers.
// Optional run watchdog enabled by defining MIPS_LOADER_TIMEOUT_EN. DRAIN_CYC must be >= 1.
module mips_prog_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int NREGS       = 32,
  parameter int RIDX_W      = 5,
  parameter int CYC_W       = 16,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk1,
  input  logic               rst_n,
  mips_prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_e;

`ifdef MIPS_LOADER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int                DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NREGS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [CYC_W-1:0]  r_cycles;
  logic [CYC_W-1:0]  w_cyc_inc;
  logic [DRN_W-1:0]  r_drain;
  logic [RIDX_W-1:0] r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic              r_have;
  logic              r_timeout;
  logic              w_start;
  logic              w_beat;
  logic              w_xfer;
  logic              w_wd_hit;

  assign w_start   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_beat    = (r_state == S_LOAD) && bus.in_valid;
  assign w_xfer    = (r_state == S_DUMP_OUT) && r_have && bus.out_ready;
  assign w_cyc_inc = (&r_cycles) ? r_cycles : r_cycles + CYC_W'(1);
  assign w_wd_hit  = WD_EN && !bus.core_halted && (w_cyc_inc >= CYC_W'(TIMEOUT_CYC));

  // NOTE: all registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output and the next state get a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.core_run  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        bus.busy = 1'b0;
        bus.done = (r_state == S_DONE);
        if (w_start) w_state_nxt = (bus.prog_len == '0) ? S_RUN : S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (w_beat && (r_addr == r_len - ADDR_W'(1))) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.core_run = 1'b1;
        if (bus.core_halted || w_wd_hit) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.core_run = 1'b1;
        if (r_drain == DRN_W'(DRAIN_CYC - 1)) w_state_nxt = S_DUMP_RD;
      end
      S_DUMP_RD: w_state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: begin
        bus.out_valid = r_have;
        if (w_xfer) w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_DUMP_RD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_addr     <= '0;
      r_cycles   <= '0;
      r_drain    <= '0;
      r_idx      <= '0;
      r_out_data <= '0;
      r_have     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_len     <= bus.prog_len;
        r_addr    <= '0;
        r_cycles  <= '0;
        r_timeout <= 1'b0;
        r_idx     <= '0;
        r_have    <= 1'b0;
      end
      if (w_beat) r_addr <= r_addr + ADDR_W'(1);
      if (r_state == S_RUN) begin
        r_cycles <= w_cyc_inc;
        r_drain  <= '0;
        if (w_wd_hit) r_timeout <= 1'b1;
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + DRN_W'(1);
      // The first DUMP_OUT cycle captures the synchronous read; the word is then held until taken.
      if ((r_state == S_DUMP_OUT) && !r_have) begin
        r_out_data <= bus.rf_rdata;
        r_have     <= 1'b1;
      end
      if (w_xfer) begin
        r_have <= 1'b0;
        r_idx  <= r_idx + RIDX_W'(1);
      end
    end
  end

  assign bus.imem_we    = w_beat;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_beat ? bus.in_data : '0;
  assign bus.rf_raddr   = r_idx;
  assign bus.out_data   = r_out_data;
  assign bus.out_idx    = r_idx;
  assign bus.out_last   = (r_state == S_DUMP_OUT) && r_have && (r_idx == LAST_IDX);
  assign bus.cycles     = r_cycles;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: instruction-level core model, imem and register file
// around the loader, randomized handshakes, directed load/run/dump scenarios.
module tb_mips_prog_loader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int NREGS    = 32;
  localparam int RIDX_W   = 5;
  localparam int CYC_W    = 16;
  localparam int HALT_LAT = 3;
  localparam int EXP_RUN  = 9 + HALT_LAT + 1;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  mips_prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RIDX_W(RIDX_W), .CYC_W(CYC_W)) bus ();

  mips_prog_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .RIDX_W(RIDX_W), .CYC_W(CYC_W),
    .DRAIN_CYC(4), .TIMEOUT_CYC(50)
  ) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                            32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  logic [31:0] exp_dump [NREGS];

  // Environment: imem written through the loader, a one-instruction-per-cycle core, register file.
  int          epoch = 1;
  logic [31:0] imem [1024];
  int          imem_ep [1024];
  int          we_total = 0;
  logic [31:0] rf [NREGS];
  logic        force_halt = 1'b0;
  logic        rf_clear = 1'b0;
  logic        c_halted = 1'b0;
  int          m_pc = 0;
  int          m_hcnt = 0;
  bit          m_hlt = 1'b0;
  logic [31:0] m_w, m_a, m_b, m_r;
  logic [4:0]  m_d;
  bit          m_wr;

  assign bus.core_halted = c_halted | force_halt;

  always @(posedge clk1) begin
    if (bus.imem_we === 1'b1) begin
      imem[bus.imem_addr]    <= bus.imem_wdata;
      imem_ep[bus.imem_addr] <= epoch;
      we_total               <= we_total + 1;
    end
  end

  always @(posedge clk1) begin
    bus.rf_rdata <= rf[bus.rf_raddr];
    if (!rst_n || rf_clear) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end
    if (bus.core_run !== 1'b1) begin
      m_pc = 0; m_hlt = 1'b0; m_hcnt = 0;
      c_halted <= 1'b0;
    end else if (!m_hlt) begin
      m_w  = (imem_ep[m_pc] == epoch) ? imem[m_pc] : 32'h0;
      m_a  = rf[m_w[25:21]];
      m_b  = rf[m_w[20:16]];
      m_d  = m_w[15:11];
      m_wr = 1'b1;
      m_r  = '0;
      case (m_w[31:26])
        6'h00: m_r = m_a + m_b;
        6'h01: m_r = m_a - m_b;
        6'h02: m_r = m_a & m_b;
        6'h03: m_r = m_a | m_b;
        6'h0a: begin m_r = m_a + {{16{m_w[15]}}, m_w[15:0]}; m_d = m_w[20:16]; end
        6'h3f: begin m_wr = 1'b0; m_hlt = 1'b1; end
        default: m_wr = 1'b0;
      endcase
      if (m_wr && (m_d != 5'd0)) rf[m_d] <= m_r;
      m_pc = m_pc + 1;
    end else if (m_hcnt < HALT_LAT) begin
      m_hcnt = m_hcnt + 1;
      if (m_hcnt == HALT_LAT) c_halted <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int i);
    case (i)
      1: return 32'd10;
      2: return 32'd20;
      3: return 32'd25;
      4: return 32'd30;
      5: return 32'd55;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int mem_mismatch(input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (imem_ep[i] != epoch || imem[i] !== prog[i]) m++;
    return m;
  endfunction

  // Fresh environment: new imem epoch (all words read as NOP), cleared register file.
  task automatic new_env();
    epoch++;
    rf_clear = 1'b1;
    @(negedge clk1);
    rf_clear = 1'b0;
    for (int i = 0; i < NREGS; i++) exp_dump[i] = exp_reg(i);
  endtask

  task automatic pulse_start(input int n);
    bus.prog_len = ADDR_W'(n);
    bus.start    = 1'b1;
    @(negedge clk1);
    bus.start    = 1'b0;
  endtask

  task automatic load_words(input int n, input bit rand_valid,
                            output int accepted, output int cyc, output int bad);
    bit v;
    accepted = 0; cyc = 0; bad = 0;
    while (accepted < n && cyc < 2000) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? prog[accepted] : $urandom;
      #1;
      if (bus.imem_we !== (v && bus.in_ready === 1'b1)) bad++;
      if (v && bus.in_ready === 1'b1) begin
        if (bus.imem_addr !== ADDR_W'(accepted) || bus.imem_wdata !== prog[accepted]) bad++;
        accepted++;
      end
      cyc++;
      @(negedge clk1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect_dump(input bit stall3, input bit rand_ready,
                              output int got, output int bad, output int hold_bad);
    int          budget = 0;
    int          stall = 0;
    bit          rdy;
    bit          pend = 1'b0;
    logic [31:0] held_d = '0;
    logic [4:0]  held_i = '0;
    got = 0; bad = 0; hold_bad = 0;
    while (got < NREGS && budget < 5000) begin
      if (pend && bus.out_valid !== 1'b1) hold_bad++;
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.out_valid === 1'b1) begin
        if (stall3 && got == 3 && stall < 5) begin
          if (stall == 0) begin held_d = bus.out_data; held_i = bus.out_idx; end
          else if (bus.out_data !== held_d || bus.out_idx !== held_i) hold_bad++;
          rdy = 1'b0;
          stall++;
        end
        if (rdy) begin
          if (bus.out_idx !== RIDX_W'(got) || bus.out_data !== exp_dump[got] ||
              bus.out_last !== (got == NREGS - 1)) bad++;
          got++;
        end
      end
      pend = (bus.out_valid === 1'b1) && !rdy;
      bus.out_ready = rdy;
      budget++;
      @(negedge clk1);
    end
    bus.out_ready = 1'b0;
    if (stall3 && stall != 5) hold_bad++;
  endtask

  task automatic finish_checks(input string tag, input int got, input int bad, input int hold_bad,
                               input int exp_cycles, input bit exp_timeout);
    check({tag, "_dump_count"}, got, NREGS);
    check({tag, "_dump_data"}, bad, 0);
    check({tag, "_dump_hold"}, hold_bad, 0);
    check({tag, "_done_busy"}, {bus.done, bus.busy}, 2'b10);
    check({tag, "_cycles"}, bus.cycles, exp_cycles);
    check({tag, "_timeout"}, bus.timeout, exp_timeout);
  endtask

  initial begin : watchdog_timer
    #3_000_000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int acc, cyc, bad, got, hold_bad, base;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.prog_len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk1);
    check("rst_ctrl", {bus.in_ready, bus.imem_we, bus.core_run, bus.out_valid, bus.out_last,
                       bus.busy, bus.done, bus.timeout}, 8'h00);
    check("rst_data", {bus.imem_addr, bus.cycles, bus.out_data}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Scenario 1: straight load, run to HLT, full-speed dump; start during RUN ignored.
    new_env();
    base = we_total;
    pulse_start(9);
    check("s1_busy_load", {bus.busy, bus.in_ready}, 2'b11);
    load_words(9, 1'b0, acc, cyc, bad);
    check("s1_beats", acc, 9);
    check("s1_throughput", cyc, 9);
    check("s1_imem_strobe", bad, 0);
    check("s1_core_run_rise", bus.core_run, 1'b1);
    bus.start = 1'b1; bus.prog_len = ADDR_W'(3);
    @(negedge clk1);
    bus.start = 1'b0;
    check("s1_start_ignored", {bus.in_ready, bus.core_run, bus.busy}, 3'b011);
    collect_dump(1'b0, 1'b0, got, bad, hold_bad);
    finish_checks("s1", got, bad, hold_bad, EXP_RUN, 1'b0);
    check("s1_mem", mem_mismatch(9), 0);
    check("s1_we_count", we_total - base, 9);

    // Scenario 2: random in_valid gaps, random out_ready, idx 3 stalled for 5 cycles.
    new_env();
    base = we_total;
    pulse_start(9);
    load_words(9, 1'b1, acc, cyc, bad);
    check("s2_beats", acc, 9);
    check("s2_imem_strobe", bad, 0);
    collect_dump(1'b1, 1'b1, got, bad, hold_bad);
    finish_checks("s2", got, bad, hold_bad, EXP_RUN, 1'b0);
    check("s2_mem", mem_mismatch(9), 0);
    check("s2_we_count", we_total - base, 9);

    // Scenario 3: empty program with halted forced; register file must come back untouched.
    epoch++;
    for (int i = 0; i < NREGS; i++) exp_dump[i] = rf[i];
    force_halt = 1'b1;
    base = we_total;
    pulse_start(0);
    check("s3_core_run_rise", {bus.core_run, bus.in_ready}, 2'b10);
    collect_dump(1'b0, 1'b1, got, bad, hold_bad);
    finish_checks("s3", got, bad, hold_bad, 1, 1'b0);
    check("s3_no_imem_we", we_total - base, 0);
    force_halt = 1'b0;

`ifdef MIPS_LOADER_TIMEOUT_EN
    // Watchdog: program without HLT must stop after exactly 50 run cycles and still dump.
    new_env();
    pulse_start(8);
    load_words(8, 1'b1, acc, cyc, bad);
    check("wd_beats", acc, 8);
    collect_dump(1'b0, 1'b1, got, bad, hold_bad);
    finish_checks("wd", got, bad, hold_bad, 50, 1'b1);
    check("wd_mem", mem_mismatch(8), 0);
`endif

    // Scenario 4: reset after 3 of 9 words, then a clean reload from address 0.
    new_env();
    pulse_start(9);
    load_words(3, 1'b0, acc, cyc, bad);
    check("s4_partial_beats", acc, 3);
    base = we_total;
    bus.in_valid = 1'b1;
    bus.in_data  = prog[3];
    rst_n = 1'b0;
    #1;
    check("s4_rst_ctrl", {bus.in_ready, bus.imem_we, bus.core_run, bus.out_valid, bus.out_last,
                          bus.busy, bus.done, bus.timeout}, 8'h00);
    check("s4_rst_data", {bus.imem_addr, bus.cycles, bus.out_data}, 64'h0);
    @(negedge clk1);
    check("s4_no_write_in_rst", we_total - base, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    new_env();
    base = we_total;
    pulse_start(9);
    load_words(9, 1'b1, acc, cyc, bad);
    check("s4_beats", acc, 9);
    check("s4_imem_strobe", bad, 0);
    collect_dump(1'b0, 1'b1, got, bad, hold_bad);
    finish_checks("s4", got, bad, hold_bad, EXP_RUN, 1'b0);
    check("s4_mem", mem_mismatch(9), 0);
    check("s4_we_count", we_total - base, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Synthesisable program loader and result harvester for the MIPS32 pipelined core. It accepts a program word stream over a valid/ready handshake and writes it into core instruction memory from address 0. It then releases the core and counts cycles until HALT, with an optional watchdog. Afterwards it streams the register file contents out over a second valid/ready port. It replaces hierarchical memory pokes and register peeks, so the same flow works in simulation and on silicon.

## Interface
Parameters:
- DATA_W, 32, instruction/register word width
- ADDR_W, 10, instruction memory address width
- NREGS, 32, registers dumped (indices 0..NREGS-1)
- RIDX_W, 5, register index width; NREGS ≤ 2^RIDX_W
- CYC_W, 16, cycle counter width
- DRAIN_CYC, 4, cycles to wait after core_halted before harvesting
- TIMEOUT_CYC, 1000, watchdog limit in run cycles

Ports:
- Clocking and reset: one clock, clk1; asynchronous active-low reset, rst_n.
- clk1  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load/run/dump sequence
- prog_len  in  ADDR_W  number of words to load, sampled on accepted start
- in_valid / in_ready  in / out  1  program word handshake
- in_data  in  DATA_W  program word
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- core_run  out  1  0 holds core at PC=0, HALTED=0, TAKEN_BRANCH=0; 1 releases it
- core_halted  in  1  core HALTED flag
- rf_raddr  out  RIDX_W  register file read index
- rf_rdata  in  DATA_W  register data, valid one cycle after rf_raddr
- out_valid / out_ready  out / in  1  register dump handshake
- out_data  out  DATA_W  register value
- out_idx  out  RIDX_W  register index of out_data
- out_last  out  1  marks index NREGS-1
- busy, done, timeout  out  1  status
- cycles  out  CYC_W  run cycles counted, saturating

## Operation
States are IDLE, LOAD, RUN, DRAIN, DUMP_RD, DUMP_OUT and DONE.
- IDLE/DONE -> start=1:
  - latch prog_len; clear cycles, timeout, done
  - go to LOAD, or to RUN if prog_len=0
- start while in any other state is ignored.
- LOAD:
  - in_ready=1
  - each in_valid&in_ready writes in_data to the current address, which starts at 0
  - after the prog_len-th word -> RUN
- RUN:
  - core_run=1; cycles increments each cycle, saturating at all-ones
  - core_halted=1 -> DRAIN
- DRAIN:
  - core_run stays 1 for DRAIN_CYC cycles so in-flight writebacks retire
  - then core_run=0 -> DUMP_RD with index 0
- DUMP_RD: drive rf_raddr=index for one cycle -> DUMP_OUT.
- DUMP_OUT:
  - register rf_rdata into out_data; out_valid=1
  - hold out_data/out_idx/out_last stable until out_ready
  - on transfer: index+1 -> DUMP_RD, or after NREGS-1 -> DONE
- DONE: done=1 until next accepted start.
- busy=1 in every state except IDLE and DONE.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-sequence aborts immediately: core_run=0, no further writes.
- imem write occurs in the same cycle as the accepted beat; no buffering.
- Load throughput is one word per cycle.
- core_run rises the cycle after the last accepted word, or the cycle after start when prog_len=0.
- cycles counts RUN cycles only, from the first cycle core_run=1 up to and including the cycle core_halted is seen.
- Dump takes at least 2 cycles per register: address cycle, then data cycle.
- out_valid never drops without a transfer.
- done rises the cycle after the last transfer.

## Configuration
- MIPS_LOADER_TIMEOUT_EN defined:
  - when cycles reaches TIMEOUT_CYC in RUN without core_halted, set timeout=1 (sticky until next start)
  - proceed to DRAIN and dump normally
- Undefined: no watchdog; timeout tied 0; RUN waits indefinitely for core_halted.

## Test plan
- Program load and harvest:
  - stimulus: load 9 words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000, with out_ready=1
  - response: R1=10, R2=20, R3=25, R4=30, R5=55; out_last only at idx 31; done=1; timeout=0
- Backpressure on both ports:
  - stimulus: in_valid toggled randomly; out_ready held 0 for 5 cycles on idx 3
  - response: memory contents identical to the first scenario; out_data for idx 3 stable while stalled; no duplicated or dropped index
- Watchdog (MIPS_LOADER_TIMEOUT_EN, TIMEOUT_CYC=50):
  - stimulus: load program without HLT
  - response: timeout=1; cycles=50; full dump still produced
- Empty program and ignored restart:
  - prog_len=0 with core_halted forced 1 -> no imem_we, cycles=1, dump completes
  - start pulsed during RUN -> ignored
- Reset mid-load:
  - stimulus: rst_n low after 3 of 9 words
  - response: all outputs 0 next edge; a fresh start reloads from address 0
